mdu_issue_queue: RTL and testbench
==================================

// Module: mdu_issue_queue
// PURPOSE
//  In-order issue queue for multiply/divide micro-op pairs, directly upstream of the MDU execute stage.
//  - Accepts HI/LO uop pairs from dispatch and tracks source-operand readiness from PRF wakeups.
//  - Drives PRF read addresses, then issues each pair so the MDU's 2-cycle writeback (HI, then LO) never collides.
// PARAMETERS
//  DEPTH    4                      queue entries, power of two
//  NWAKE    4                      wakeup broadcast ports
//  MUL_LAT  `MDU_MUL_CYCLE+1       cycles from issue-register output to HI writeback, multiply
//  DIV_LAT  `MDU_DIV_CYCLE+1       cycles from issue-register output to HI writeback, divide
//  RSV_LEN  DIV_LAT+2              writeback reservation window length
// PORTS
//  clk          in   1               clock
//  rst          in   1               async reset, active-high
//  flush        in   1               pipeline flush (mispredict/exception)
//  enq_valid    in   1               dispatch presents a pair
//  enq_ready    out  1               queue can accept
//  enq_hi       in   UOPBundle       HI uop (carries rs0/rs1 PRFNum)
//  enq_lo       in   UOPBundle       LO uop
//  enq_rs_rdy   in   2               rs0/rs1 already ready at dispatch
//  wk_valid     in   NWAKE           wakeup valid
//  wk_preg      in   NWAKE*PRFNum    woken physical registers
//  prf_raddr0   out  PRFNum          head rs0 read address, combinational
//  prf_raddr1   out  PRFNum          head rs1 read address, combinational
//  iss_hi       out  UOPBundle       registered HI uop to MDU
//  iss_lo       out  UOPBundle       registered LO uop to MDU
// BEHAVIOUR
//  Reset (async): queue empty, pointers 0, reservation vector 0; iss_hi/iss_lo = {uOP: NOP_U, valid: 0}.
//  Storage: circular buffer; head/tail pointers are $clog2(DEPTH)+1 bits with a wrap bit.
//  - full = (index bits equal && wrap bits differ); enq_ready = !full.
//  - Enqueue when enq_valid && enq_ready; tail advances and wraps DEPTH-1 -> 0.
//  - An entry stores hi, lo, rdy[1:0]; rdy initialises from enq_rs_rdy OR same-cycle wakeup match.
//  Wakeup:
//  - Any wk_valid[i] with wk_preg[i] equal to an entry's rs0 or rs1 sets the matching rdy bit; bits are sticky.
//  - $0 sources (preg 0) are always ready.
//  Issue:
//  - Head only; strictly in order.
//  - can_issue = head valid && &rdy && !rsv[L] && !rsv[L+1] && !flush, where L = MUL_LAT or DIV_LAT by head hi.uOP (MULTHI_U/MULTUHI_U vs DIVHI_U/DIVUHI_U).
//  - On issue: iss_hi/iss_lo <= head pair, head advances; otherwise iss_* <= NOP, valid 0.
//  - At most one pair issues per cycle.
//  - Operand data arrives from the PRF alongside iss_*: prf_raddr* come from the head, 1-cycle read.
//  Reservation vector rsv[RSV_LEN-1:0]:
//  - Shifts toward index 0 every cycle.
//  - An issue sets bits L and L+1 after the shift.
//  - Guarantees no two pairs share a writeback cycle; a mul issued after a div can still fill gaps.
//  Simultaneous events:
//  - Enqueue + issue in one cycle: both occur; count unchanged.
//  - Enqueue when full: ignored (enq_ready=0).
//  - Issue when empty: none.
//  Flush (synchronous):
//  - Next edge: queue emptied, iss_* <= NOP.
//  - Reservation bits are kept, because in-flight MDU ops still write back.
//  - Enqueue in the flush cycle is dropped.
//  Async reset mid-operation: everything clears immediately, including rsv.
// CONFIGURATION
//  MDU_IQ_BYPASS_EN defined:
//  - When the queue is empty and the enqueued pair has enq_rs_rdy==2'b11 and the slots are free, the pair issues the same cycle it is enqueued (not written into the queue).
//  - prf_raddr* then select enq_hi sources.
//  MDU_IQ_BYPASS_EN undefined:
//  - Minimum enqueue-to-iss latency is 2 cycles (queue write, then head issue).
// STRUCTURE
//  Shared package/defines:
//  - MDU_MUL_CYCLE, MDU_DIV_CYCLE, UOPBundle, PRFNum, uOP enum: already shared.
//  - Add typedef MDUIQEntry {hi, lo, rdy[1:0]}.
//  Sub-module mdu_wb_reservation:
//  - Shift vector with query(L) and set(L) ports.
//  - Reused by any future fixed-latency unit sharing a writeback port.
// TESTING
//  1. Reset: all outputs idle. Enqueue MULT pair, rdy=11 -> iss_hi.valid=1 two cycles later (one cycle with bypass); queue empty after.
//  2. Enqueue DIV pair with rs1 not ready; wakeup of that preg 5 cycles later -> issue on the following cycle, never earlier.
//  3. DIV at cycle t, MULT ready at t+1 with DIV_LAT-MUL_LAT = 1 or 2 (colliding) -> MULT held until rsv clear; check no overlapping writeback cycles.
//  4. Enqueue 4 pairs with head blocked -> enq_ready=0; 5th enqueue ignored; release head -> pointers wrap and order is preserved (ids 0..3).
//  5. Flush with 3 entries plus a concurrent enqueue -> empty next cycle, iss_* NOP, rsv bits from an earlier issue still block a new DIV.
//  6. Assert rst between clock edges mid-issue -> outputs NOP immediately; queue empty after release.

Source files
------------

// File: rtl/mdu_issue_queue_pkg.sv
// Shared types and constants for the MDU issue queue.
// Latencies derive from MDU_MUL_CYCLE / MDU_DIV_CYCLE, which normally come
// from the shared defines; local fallbacks keep this slice self-contained.
`ifndef MDU_MUL_CYCLE
`define MDU_MUL_CYCLE 2
`endif
`ifndef MDU_DIV_CYCLE
`define MDU_DIV_CYCLE 3
`endif

package mdu_issue_queue_pkg;

   localparam int PRF_W    = 6;
   localparam int IQ_DEPTH = 4;
   localparam int IQ_NWAKE = 4;
   localparam int MUL_LAT  = `MDU_MUL_CYCLE + 1;
   localparam int DIV_LAT  = `MDU_DIV_CYCLE + 1;
   localparam int RSV_LEN  = DIV_LAT + 2;
   localparam int LAT_W    = $clog2(RSV_LEN);

   typedef logic [PRF_W-1:0] PRFNum;

   typedef enum logic [3:0] {
      NOP_U     = 4'd0,
      MULTHI_U  = 4'd1,
      MULTUHI_U = 4'd2,
      MULTLO_U  = 4'd3,
      MULTULO_U = 4'd4,
      DIVHI_U   = 4'd5,
      DIVUHI_U  = 4'd6,
      DIVLO_U   = 4'd7,
      DIVULO_U  = 4'd8
   } uop_e;

   typedef struct packed {
      uop_e        uOP;
      logic        valid;
      PRFNum       rs0;
      PRFNum       rs1;
      PRFNum       rd;
      logic [7:0]  id;
   } UOPBundle;

   typedef struct packed {
      UOPBundle    hi;
      UOPBundle    lo;
      logic [1:0]  rdy;
   } MDUIQEntry;

   localparam UOPBundle NOP_UOP = '{uOP: NOP_U, valid: 1'b0, rs0: 6'd0,
                                    rs1: 6'd0, rd: 6'd0, id: 8'd0};

   // HI-writeback latency of a pair, selected by its HI uop.
   function automatic logic [LAT_W-1:0] wb_lat(input uop_e op);
      case (op)
         DIVHI_U, DIVUHI_U: wb_lat = LAT_W'(DIV_LAT);
         default:           wb_lat = LAT_W'(MUL_LAT);
      endcase
   endfunction

endpackage

// File: rtl/mdu_wb_reservation.sv
// Writeback-slot reservation vector for fixed-latency units sharing one
// writeback port. Bit k marks a booked slot; the vector shifts toward bit 0
// each cycle. A query reports whether slots L and L+1 are both free; a set
// books L and L+1 after the shift. Only reset clears it.
module mdu_wb_reservation #(
   parameter int LEN   = 6,
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LAT_W-1:0] query_lat,
   output logic             query_free,
   input  logic             set_en,
   input  logic [LAT_W-1:0] set_lat
);

   logic [LEN-1:0] rsv_q;
   logic [LEN-1:0] rsv_d;
   logic [LEN-1:0] query_mask_s;
   logic [LEN-1:0] set_mask_s;

   // Two-slot mask covering the HI and LO writeback of one pair.
   function automatic logic [LEN-1:0] pair_mask(input logic [LAT_W-1:0] lat);
      for (int k = 0; k < LEN; k++) begin
         pair_mask[k] = ({1'b0, lat} == (LAT_W+1)'(k)) ||
                        (({1'b0, lat} + (LAT_W+1)'(1)) == (LAT_W+1)'(k));
      end
   endfunction

   // Query the current vector and compute the shifted, newly booked vector.
   always_comb begin
      query_mask_s = pair_mask(query_lat);
      set_mask_s   = pair_mask(set_lat);
      query_free   = ~|(rsv_q & query_mask_s);
      if (set_en) begin
         rsv_d = {1'b0, rsv_q[LEN-1:1]} | set_mask_s;
      end else begin
         rsv_d = {1'b0, rsv_q[LEN-1:1]};
      end
   end

   // Reservation state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsv_q <= {LEN{1'b0}};
      end else begin
         rsv_q <= rsv_d;
      end
   end

endmodule

// File: rtl/mdu_issue_queue.sv
// In-order issue queue for MDU HI/LO micro-op pairs. Tracks source readiness
// from PRF wakeups, drives head PRF read addresses and issues the head pair
// only when its two writeback slots are free.
// Optional feature: define MDU_IQ_BYPASS_EN to let a fully ready pair skip
// an empty queue and issue in the cycle it is enqueued.
module mdu_issue_queue
   import mdu_issue_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int NWAKE = IQ_NWAKE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  UOPBundle               enq_hi,
   input  UOPBundle               enq_lo,
   input  logic [1:0]             enq_rs_rdy,
   input  logic [NWAKE-1:0]       wk_valid,
   input  logic [NWAKE*PRF_W-1:0] wk_preg,
   output PRFNum                  prf_raddr0,
   output PRFNum                  prf_raddr1,
   output UOPBundle               iss_hi,
   output UOPBundle               iss_lo
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   MDUIQEntry        ent_q [DEPTH];
   MDUIQEntry        ent_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   UOPBundle         iss_hi_q, iss_hi_d;
   UOPBundle         iss_lo_q, iss_lo_d;

   MDUIQEntry        head_ent_s;
   logic             full_s;
   logic             empty_s;
   logic [1:0]       enq_rdy_s;
   logic [LAT_W-1:0] query_lat_s;
   logic             rsv_free_s;
   logic             can_issue_s;
   logic             bypass_s;
   logic             issue_s;
   logic             do_enq_s;

   // A source is ready when it is $0 or named by any valid wakeup port.
   function automatic logic src_woken(input PRFNum preg,
                                      input logic [NWAKE-1:0] vld,
                                      input logic [NWAKE*PRF_W-1:0] pregs);
      src_woken = (preg == {PRF_W{1'b0}});
      for (int i = 0; i < NWAKE; i++) begin
         src_woken = src_woken | (vld[i] && (pregs[i*PRF_W +: PRF_W] == preg));
      end
   endfunction

   // Queue status, head view, latency query and PRF read addresses.
   always_comb begin
      head_ent_s   = ent_q[head_q[IDX_W-1:0]];
      empty_s      = (head_q == tail_q);
      full_s       = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                     (head_q[IDX_W] != tail_q[IDX_W]);
      enq_ready    = !full_s;
      enq_rdy_s[0] = enq_rs_rdy[0] | src_woken(enq_hi.rs0, wk_valid, wk_preg);
      enq_rdy_s[1] = enq_rs_rdy[1] | src_woken(enq_hi.rs1, wk_valid, wk_preg);
`ifdef MDU_IQ_BYPASS_EN
      if (empty_s) begin
         query_lat_s = wb_lat(enq_hi.uOP);
         prf_raddr0  = enq_hi.rs0;
         prf_raddr1  = enq_hi.rs1;
      end else begin
         query_lat_s = wb_lat(head_ent_s.hi.uOP);
         prf_raddr0  = head_ent_s.hi.rs0;
         prf_raddr1  = head_ent_s.hi.rs1;
      end
`else
      query_lat_s = wb_lat(head_ent_s.hi.uOP);
      prf_raddr0  = head_ent_s.hi.rs0;
      prf_raddr1  = head_ent_s.hi.rs1;
`endif
   end

   // Issue, bypass and enqueue decisions for this cycle.
   always_comb begin
      can_issue_s = !empty_s && (&head_ent_s.rdy) && rsv_free_s && !flush;
`ifdef MDU_IQ_BYPASS_EN
      bypass_s    = empty_s && enq_valid && (enq_rs_rdy == 2'b11) &&
                    rsv_free_s && !flush;
`else
      bypass_s    = 1'b0;
`endif
      issue_s     = can_issue_s | bypass_s;
      do_enq_s    = enq_valid && !full_s && !flush && !bypass_s;
   end

   // Next-state: sticky wakeups, enqueue write, pointer moves, issue register.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]        = ent_q[i];
         ent_d[i].rdy[0] = ent_q[i].rdy[0] | src_woken(ent_q[i].hi.rs0, wk_valid, wk_preg);
         ent_d[i].rdy[1] = ent_q[i].rdy[1] | src_woken(ent_q[i].hi.rs1, wk_valid, wk_preg);
      end
      if (do_enq_s) begin
         ent_d[tail_q[IDX_W-1:0]] = '{hi: enq_hi, lo: enq_lo, rdy: enq_rdy_s};
      end else begin
         ent_d[tail_q[IDX_W-1:0]] = ent_d[tail_q[IDX_W-1:0]];
      end

      if (can_issue_s) begin
         head_d   = head_q + PTR_W'(1);
         iss_hi_d = head_ent_s.hi;
         iss_lo_d = head_ent_s.lo;
      end else if (bypass_s) begin
         head_d   = head_q;
         iss_hi_d = enq_hi;
         iss_lo_d = enq_lo;
      end else begin
         head_d   = head_q;
         iss_hi_d = NOP_UOP;
         iss_lo_d = NOP_UOP;
      end

      // Flush empties the queue by collapsing tail onto the current head.
      if (flush) begin
         tail_d = head_q;
      end else if (do_enq_s) begin
         tail_d = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
   end

   // Queue storage, pointers and issue registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= {$bits(MDUIQEntry){1'b0}};
         end
         head_q   <= {PTR_W{1'b0}};
         tail_q   <= {PTR_W{1'b0}};
         iss_hi_q <= NOP_UOP;
         iss_lo_q <= NOP_UOP;
      end else begin
         ent_q    <= ent_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         iss_hi_q <= iss_hi_d;
         iss_lo_q <= iss_lo_d;
      end
   end

   assign iss_hi = iss_hi_q;
   assign iss_lo = iss_lo_q;

   // Writeback slots survive flush because in-flight MDU ops still retire.
   mdu_wb_reservation #(
      .LEN   (RSV_LEN),
      .LAT_W (LAT_W)
   ) u_wb_rsv (
      .clk        (clk),
      .rst        (rst),
      .query_lat  (query_lat_s),
      .query_free (rsv_free_s),
      .set_en     (issue_s),
      .set_lat    (query_lat_s)
   );

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Self-checking bench for mdu_issue_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model
// that books writeback slots by absolute cycle number.
module tb_mdu_issue_queue;
   import mdu_issue_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int NWAKE = 4;
`ifdef MDU_IQ_BYPASS_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   flush;
   logic                   enq_valid;
   logic                   enq_ready;
   UOPBundle               enq_hi, enq_lo;
   logic [1:0]             enq_rs_rdy;
   logic [NWAKE-1:0]       wk_valid;
   logic [NWAKE*PRF_W-1:0] wk_preg;
   PRFNum                  prf_raddr0, prf_raddr1;
   UOPBundle               iss_hi, iss_lo;

   mdu_issue_queue #(.DEPTH(DEPTH), .NWAKE(NWAKE)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
      .enq_ready(enq_ready), .enq_hi(enq_hi), .enq_lo(enq_lo),
      .enq_rs_rdy(enq_rs_rdy), .wk_valid(wk_valid), .wk_preg(wk_preg),
      .prf_raddr0(prf_raddr0), .prf_raddr1(prf_raddr1),
      .iss_hi(iss_hi), .iss_lo(iss_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      UOPBundle hi;
      UOPBundle lo;
      bit       r0;
      bit       r1;
   } ment_t;

   ment_t      mq[$];
   bit         busy[int];
   bit         dut_busy[int];
   int         cyc = 0;
   UOPBundle   exp_hi = NOP_UOP;
   UOPBundle   exp_lo = NOP_UOP;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] next_id = 8'd0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int lat_of(input uop_e op);
      return (op == DIVHI_U || op == DIVUHI_U) ? DIV_LAT : MUL_LAT;
   endfunction

   function automatic uop_e lo_of(input uop_e op);
      case (op)
         MULTHI_U:  return MULTLO_U;
         MULTUHI_U: return MULTULO_U;
         DIVHI_U:   return DIVLO_U;
         default:   return DIVULO_U;
      endcase
   endfunction

   function automatic bit woken(input PRFNum p);
      if (p == 6'd0) return 1'b1;
      for (int i = 0; i < NWAKE; i++)
         if (wk_valid[i] && wk_preg[i*PRF_W +: PRF_W] == p) return 1'b1;
      return 1'b0;
   endfunction

   // Edge n issuing with latency L writes back at n+L and n+L+1; the check
   // sees the booking state as of the previous cycle (slots n+L-1 and n+L).
   function automatic bit slots_free(input int n, input int lat);
      return !busy.exists(n + lat - 1) && !busy.exists(n + lat);
   endfunction

   task automatic model_step();
      int       n = cyc + 1;
      int       sz0 = mq.size();
      bit       iss = 1'b0;
      bit       byp = 1'b0;
      UOPBundle nh = NOP_UOP;
      UOPBundle nl = NOP_UOP;
      if (!flush && sz0 > 0 && mq[0].r0 && mq[0].r1 && slots_free(n, lat_of(mq[0].hi.uOP))) begin
         nh = mq[0].hi; nl = mq[0].lo; iss = 1'b1;
         void'(mq.pop_front());
      end
`ifdef MDU_IQ_BYPASS_EN
      else if (!flush && sz0 == 0 && enq_valid && enq_rs_rdy == 2'b11 &&
               slots_free(n, lat_of(enq_hi.uOP))) begin
         nh = enq_hi; nl = enq_lo; iss = 1'b1; byp = 1'b1;
      end
`endif
      foreach (mq[i]) begin
         mq[i].r0 = mq[i].r0 | woken(mq[i].hi.rs0);
         mq[i].r1 = mq[i].r1 | woken(mq[i].hi.rs1);
      end
      if (enq_valid && sz0 < DEPTH && !flush && !byp)
         mq.push_back('{hi: enq_hi, lo: enq_lo,
                        r0: enq_rs_rdy[0] | woken(enq_hi.rs0),
                        r1: enq_rs_rdy[1] | woken(enq_hi.rs1)});
      if (flush) mq.delete();
      if (iss) begin
         busy[n + lat_of(nh.uOP)]     = 1'b1;
         busy[n + lat_of(nh.uOP) + 1] = 1'b1;
      end
      exp_hi = nh;
      exp_lo = nl;
      cyc    = n;
   endtask

   task automatic model_reset();
      mq.delete();
      busy.delete();
      dut_busy.delete();
      exp_hi = NOP_UOP;
      exp_lo = NOP_UOP;
   endtask

   task automatic compare();
      int lat;
      check_eq("iss_hi", 64'(iss_hi), 64'(exp_hi));
      check_eq("iss_lo", 64'(iss_lo), 64'(exp_lo));
      check_eq("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
      if (mq.size() > 0) begin
         check_eq("prf_raddr0", 64'(prf_raddr0), 64'(mq[0].hi.rs0));
         check_eq("prf_raddr1", 64'(prf_raddr1), 64'(mq[0].hi.rs1));
      end
      if (iss_hi.valid) begin
         lat = lat_of(iss_hi.uOP);
         check_eq("wb_overlap", 64'(dut_busy.exists(cyc + lat) || dut_busy.exists(cyc + lat + 1)), 64'd0);
         dut_busy[cyc + lat]     = 1'b1;
         dut_busy[cyc + lat + 1] = 1'b1;
      end
   endtask

   // Inputs are already driven at a falling edge; run one clock and check.
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      enq_valid = 1'b0;
      flush     = 1'b0;
      wk_valid  = '0;
   endtask

   task automatic drive_pair(input uop_e op, input PRFNum a, input PRFNum b, input logic [1:0] r);
      enq_valid  = 1'b1;
      enq_hi     = '{uOP: op, valid: 1'b1, rs0: a, rs1: b, rd: PRFNum'($urandom_range(1, 63)), id: next_id};
      enq_lo     = '{uOP: lo_of(op), valid: 1'b1, rs0: a, rs1: b, rd: PRFNum'($urandom_range(1, 63)), id: next_id};
      enq_rs_rdy = r;
      next_id    = next_id + 8'd1;
   endtask

   task automatic wake(input int port, input PRFNum p);
      wk_valid[port] = 1'b1;
      wk_preg[port*PRF_W +: PRF_W] = p;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   uop_e ops[4] = '{MULTHI_U, MULTUHI_U, DIVHI_U, DIVUHI_U};

   initial begin
      int n;
      int exp_id;
      idle();
      enq_hi = NOP_UOP; enq_lo = NOP_UOP; enq_rs_rdy = 2'b00; wk_preg = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      compare();

      // 1: ready MULT pair, enqueue-to-issue latency
      drive_pair(MULTHI_U, 6'd1, 6'd2, 2'b11);
      step();
      n = 1;
      idle();
      while (!iss_hi.valid && n < 8) begin step(); n++; end
      check_eq("t1_latency", 64'(n), 64'(EXP_LAT));
      repeat (3) step();

      // 2: DIV waits on rs1 wakeup, issues exactly one cycle after it
      drive_pair(DIVHI_U, 6'd3, 6'd9, 2'b01);
      step(); idle();
      repeat (5) step();
      wake(2, 6'd9);
      step(); idle();
      check_eq("t2_not_early", 64'(iss_hi.valid), 64'd0);
      step();
      check_eq("t2_issue", 64'(iss_hi.valid), 64'd1);
      repeat (4) step();

      // 3: DIV then MULT back to back, MULT must not collide
      drive_pair(DIVHI_U, 6'd1, 6'd2, 2'b11); step();
      drive_pair(MULTHI_U, 6'd3, 6'd4, 2'b11); step();
      idle();
      repeat (10) step();

      // 4: blocked head, fill, overflow attempt, drain in order
      next_id = 8'd0;
      drive_pair(MULTHI_U, 6'd12, 6'd0, 2'b00); step();
      for (int i = 0; i < 3; i++) begin drive_pair(MULTUHI_U, 6'd1, 6'd2, 2'b11); step(); end
      check_eq("t4_full", 64'(enq_ready), 64'd0);
      drive_pair(MULTHI_U, 6'd1, 6'd2, 2'b11); step();
      idle(); step();
      wake(0, 6'd12);
      exp_id = 0;
      for (int i = 0; i < 16; i++) begin
         step(); idle();
         if (iss_hi.valid) begin
            check_eq("t4_order", 64'(iss_hi.id), 64'(exp_id));
            exp_id++;
         end
      end
      check_eq("t4_count", 64'(exp_id), 64'd4);

      // 5a: flush three blocked entries with a concurrent enqueue
      for (int i = 0; i < 3; i++) begin
         drive_pair(DIVHI_U, PRFNum'(20 + 2*i), PRFNum'(21 + 2*i), 2'b00); step();
      end
      drive_pair(MULTHI_U, 6'd1, 6'd2, 2'b11);
      flush = 1'b1;
      step(); idle();
      check_eq("t5_empty", 64'(enq_ready), 64'd1);
      for (int i = 0; i < 4; i++) wake(i, PRFNum'(20 + i));
      step(); idle();
      wake(0, 6'd24); wake(1, 6'd25);
      step(); idle();
      repeat (3) step();

      // 5b: reservation from an issue before flush still holds a new MULT
      drive_pair(DIVHI_U, 6'd1, 6'd2, 2'b11); step();
      drive_pair(DIVHI_U, 6'd30, 6'd31, 2'b00); step();
      idle(); flush = 1'b1; step();
      idle(); drive_pair(MULTHI_U, 6'd3, 6'd4, 2'b11); step();
      idle(); step();
      check_eq("t5_mul_held", 64'(iss_hi.valid), 64'd0);
      repeat (8) step();

      // 6: async reset between edges while pairs are issuing
      drive_pair(MULTHI_U, 6'd1, 6'd2, 2'b11); step();
      drive_pair(MULTHI_U, 6'd3, 6'd4, 2'b11); step();
      idle(); step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("t6_rst_hi", 64'(iss_hi), 64'(NOP_UOP));
      check_eq("t6_rst_lo", 64'(iss_lo), 64'(NOP_UOP));
      check_eq("t6_rst_rdy", 64'(enq_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare();
      repeat (2) step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         flush = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 2) != 0)
            drive_pair(ops[$urandom_range(0, 3)], PRFNum'($urandom_range(0, 7)),
                       PRFNum'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         else
            enq_valid = 1'b0;
         for (int i = 0; i < NWAKE; i++) begin
            wk_valid[i] = ($urandom_range(0, 3) == 0);
            wk_preg[i*PRF_W +: PRF_W] = PRFNum'($urandom_range(1, 7));
         end
         step();
      end
      idle();
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
